oam_sprite_eval: RTL and testbench

PPU-side reader of the sprite Object Attribute Memory that the CPU fills through OAM writes. At each scanline start it scans all 64 OAM entries through the OAM read port and selects up to 8 sprites that intersect the line. It then streams the selected sprites, lowest sprite number first, to the sprite renderer over a valid/ready handshake.

---
 rtl/oam_sprite_eval_pkg.sv | 40 ++++
 rtl/sprite_line_buf.sv | 46 ++++
 rtl/oam_sprite_eval.sv | 155 +++++++++++++++
 tb/tb_oam_sprite_eval.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_sprite_eval_pkg.sv
// Shared OAM layout, sizing and state encoding for sprite evaluation.
// Field offsets are also used by the CPU-side OAM write path.
package oam_sprite_eval_pkg;

  localparam int NUM_SPR      = 64;
  localparam int MAX_PER_LINE = 8;
  localparam int SPR_H        = 8;
  localparam int COORD_W      = 10;

  localparam int ADDR_W = $clog2(NUM_SPR);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int PTR_W  = $clog2(MAX_PER_LINE);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DIFF_W = COORD_W + 1;

  localparam int IDX_W  = 6;
  localparam int ATTR_W = 8;

  localparam int Y_LSB     = 0;
  localparam int X_LSB     = Y_LSB + COORD_W;
  localparam int ATTR_LSB  = X_LSB + COORD_W;
  localparam int INDEX_LSB = ATTR_LSB + ATTR_W;
  localparam int OAM_W     = INDEX_LSB + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  snum;
    logic [IDX_W-1:0]   index;
    logic [ATTR_W-1:0]  attr;
    logic [COORD_W-1:0] x;
    logic [ROW_W-1:0]   row;
  } spr_ent_t;

endpackage

// File: rtl/sprite_line_buf.sv
// Secondary sprite buffer: in-order writes, in-order reads, bulk clear.
// Ports: i_clr, i_wr/i_wdata, i_rd_adv -> o_rdata, o_count, o_rd_ptr, o_full.
module sprite_line_buf
  import oam_sprite_eval_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  spr_ent_t         i_wdata,
  input  logic             i_rd_adv,
  output spr_ent_t         o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_rd_ptr,
  output logic             o_full
);

  spr_ent_t         r_mem [MAX_PER_LINE];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_rd  <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++)
        r_mem[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_rd  <= '0;
    end else begin
      if (i_wr && !o_full) begin
        r_mem[r_cnt[PTR_W-1:0]] <= i_wdata;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_rd_adv && (r_rd != r_cnt))
        r_rd <= r_rd + CNT_W'(1);
    end
  end

  assign o_full   = (r_cnt == CNT_W'(MAX_PER_LINE));
  assign o_rdata  = r_mem[r_rd[PTR_W-1:0]];
  assign o_count  = r_cnt;
  assign o_rd_ptr = r_rd;

endmodule

// File: rtl/oam_sprite_eval.sv
// Per-scanline OAM scan: picks up to 8 intersecting sprites, streams them.
// Ports: line_start/line_num in, OAM read port, valid/ready sprite stream.
module oam_sprite_eval
  import oam_sprite_eval_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               line_start,
  input  logic [COORD_W-1:0] line_num,
  output logic               oam_rd_en,
  output logic [ADDR_W-1:0]  oam_rd_addr,
  input  logic [OAM_W-1:0]   oam_rd_data,
  output logic               spr_valid,
  input  logic               spr_ready,
  output logic [ADDR_W-1:0]  spr_snum,
  output logic [IDX_W-1:0]   spr_index,
  output logic [ATTR_W-1:0]  spr_attr,
  output logic [COORD_W-1:0] spr_x,
  output logic [ROW_W-1:0]   spr_row,
  output logic [CNT_W-1:0]   spr_count,
  output logic               overflow,
  output logic               eval_busy,
  output logic               eval_done
);

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_rd_snum;
  logic               r_rd_vld;
  logic               r_ovf;
  logic               r_done;
  logic [COORD_W-1:0] r_line;

  logic [DIFF_W-1:0]  w_diff;
  logic               w_hit;
  logic               w_wr;
  logic               w_adv;
  logic               w_last;
  logic               w_valid;
  logic               w_empty;
  spr_ent_t           w_wdata;
  spr_ent_t           w_rdata;
  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   w_rd_ptr;
  logic               w_full;

  // Zero-extended subtract: a negative result sets the top bit,
  // so sprites never wrap from the bottom of the screen to the top.
  assign w_diff = {1'b0, r_line}
                - {1'b0, oam_rd_data[Y_LSB +: COORD_W]};
  assign w_hit  = r_rd_vld && !w_diff[COORD_W]
               && (w_diff < DIFF_W'(SPR_H));

  assign w_wdata.snum  = r_rd_snum;
  assign w_wdata.index = oam_rd_data[INDEX_LSB +: IDX_W];
  assign w_wdata.attr  = oam_rd_data[ATTR_LSB +: ATTR_W];
  assign w_wdata.x     = oam_rd_data[X_LSB +: COORD_W];
  assign w_wdata.row   = w_diff[ROW_W-1:0];

  assign w_wr    = w_hit && !line_start;
  assign w_empty = (w_cnt == '0);
  assign w_valid = (r_state == S_OUT) && !w_empty;
  assign w_adv   = w_valid && spr_ready;
  assign w_last  = ((w_rd_ptr + CNT_W'(1)) == w_cnt);

  sprite_line_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (line_start),
    .i_wr     (w_wr),
    .i_wdata  (w_wdata),
    .i_rd_adv (w_adv),
    .o_rdata  (w_rdata),
    .o_count  (w_cnt),
    .o_rd_ptr (w_rd_ptr),
    .o_full   (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    oam_rd_en = 1'b0;
    eval_busy = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        eval_busy = 1'b0;
        if (line_start) w_next = S_SCAN;
      end
      S_SCAN: begin
        oam_rd_en = 1'b1;
        if (line_start)
          w_next = S_SCAN;
        else if (r_addr == ADDR_W'(NUM_SPR - 1))
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_next = line_start ? S_SCAN : S_OUT;
      end
      S_OUT: begin
        if (line_start)
          w_next = S_SCAN;
        else if (w_empty || (w_adv && w_last))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_rd_snum <= '0;
      r_rd_vld  <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_line    <= '0;
    end else begin
      // Abort drops the datum still in flight from the old scan.
      r_rd_vld  <= (r_state == S_SCAN) && !line_start;
      r_rd_snum <= r_addr;
      r_done    <= (r_state == S_OUT) && !line_start
                && w_adv && w_last;
      if (line_start) begin
        r_line <= line_num;
        r_addr <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (r_state == S_SCAN)
          r_addr <= r_addr + ADDR_W'(1);
        if (w_hit && w_full)
          r_ovf <= 1'b1;
      end
    end
  end

  assign oam_rd_addr = r_addr;
  assign spr_valid   = w_valid;
  assign spr_snum    = w_valid ? w_rdata.snum  : '0;
  assign spr_index   = w_valid ? w_rdata.index : '0;
  assign spr_attr    = w_valid ? w_rdata.attr  : '0;
  assign spr_x       = w_valid ? w_rdata.x     : '0;
  assign spr_row     = w_valid ? w_rdata.row   : '0;
  assign spr_count   = w_cnt;
  assign overflow    = r_ovf;
  // Empty line finishes in its first OUT cycle; otherwise the
  // registered pulse follows the last accepted entry.
  assign eval_done   = r_done
                    || ((r_state == S_OUT) && w_empty && !line_start);

endmodule

// File: tb/tb_oam_sprite_eval.sv
// Directed self-checking bench for oam_sprite_eval.
// Behavioural OAM with one-cycle read latency feeds the DUT.
module tb_oam_sprite_eval;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_num = '0;
  logic        oam_rd_en;
  logic [5:0]  oam_rd_addr;
  logic [33:0] oam_rd_data = '0;
  logic        spr_valid;
  logic        spr_ready = 1'b0;
  logic [5:0]  spr_snum;
  logic [5:0]  spr_index;
  logic [7:0]  spr_attr;
  logic [9:0]  spr_x;
  logic [2:0]  spr_row;
  logic [3:0]  spr_count;
  logic        overflow;
  logic        eval_busy;
  logic        eval_done;

  logic [33:0] oam [64];
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int valid_cnt = 0;

  oam_sprite_eval dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .line_num    (line_num),
    .oam_rd_en   (oam_rd_en),
    .oam_rd_addr (oam_rd_addr),
    .oam_rd_data (oam_rd_data),
    .spr_valid   (spr_valid),
    .spr_ready   (spr_ready),
    .spr_snum    (spr_snum),
    .spr_index   (spr_index),
    .spr_attr    (spr_attr),
    .spr_x       (spr_x),
    .spr_row     (spr_row),
    .spr_count   (spr_count),
    .overflow    (overflow),
    .eval_busy   (eval_busy),
    .eval_done   (eval_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (oam_rd_en) oam_rd_data <= oam[oam_rd_addr];

  always @(posedge clk) begin
    if (eval_done) done_cnt++;
    if (spr_valid) valid_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  function automatic logic [33:0] mk(
    input logic [5:0] idx, input logic [7:0] at,
    input logic [9:0] x, input logic [9:0] y);
    return {idx, at, x, y};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < 64; i++)
      oam[i] = mk(6'd0, 8'd0, 10'd0, 10'd1000);
  endtask

  // Returns at the falling edge inside cycle k+1.
  task automatic start_line(input logic [9:0] l);
    @(negedge clk);
    line_num = l;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (eval_busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (eval_busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0",
               eval_busy, t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [47:0] v;
    spr_ready = 1'b1;
    repeat (2) @(negedge clk);
    v = {oam_rd_en, oam_rd_addr, spr_valid, spr_snum, spr_index,
         spr_attr, spr_x, spr_row, spr_count, overflow,
         eval_busy, eval_done};
    n_tests++;
    if (v !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", v);
    end
    rst = 1'b1;
    clear_oam();
    oam[40] = mk(6'd1, 8'd2, 10'd3, 10'd60);
    start_line(10'd60);
    repeat (30) @(negedge clk);
    n_tests++;
    if (oam_rd_addr !== 6'd30 || oam_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_addr30: addr=%0d en=%b want 30/1",
               oam_rd_addr, oam_rd_en);
    end
    rst = 1'b0;
    #1;
    v = {oam_rd_en, oam_rd_addr, spr_valid, spr_snum, spr_index,
         spr_attr, spr_x, spr_row, spr_count, overflow,
         eval_busy, eval_done};
    n_tests++;
    if (v !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_mid_scan: got %h want 0", v);
    end
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (80) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d want 0", done_cnt);
    end
    start_line(10'd60);
    n_tests++;
    if (oam_rd_addr !== 6'd0 || oam_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rescan: addr=%0d en=%b want 0/1",
               oam_rd_addr, oam_rd_en);
    end
    wait_idle();
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL reset_rescan_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_single_hit();
    clear_oam();
    oam[5] = mk(6'h2A, 8'h5C, 10'd321, 10'd100);
    spr_ready = 1'b1;
    start_line(10'd103);
    repeat (64) @(negedge clk);
    n_tests++;
    if (spr_valid !== 1'b0 || eval_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_k65: valid=%b busy=%b want 0/1",
               spr_valid, eval_busy);
    end
    @(negedge clk);
    n_tests++;
    if ({spr_valid, spr_snum, spr_index, spr_attr, spr_x, spr_row}
        !== {1'b1, 6'd5, 6'h2A, 8'h5C, 10'd321, 3'd3}) begin
      n_fail++;
      $display("FAIL single_entry: v=%b s=%0d i=%h a=%h x=%0d r=%0d",
               spr_valid, spr_snum, spr_index, spr_attr, spr_x,
               spr_row);
    end
    n_tests++;
    if ({spr_count, overflow, eval_done} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_cnt: cnt=%0d ovf=%b done=%b want 1/0/0",
               spr_count, overflow, eval_done);
    end
    @(negedge clk);
    n_tests++;
    if ({eval_done, spr_valid, eval_busy, spr_count}
        !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL single_done: d=%b v=%b b=%b c=%0d want 1/0/0/1",
               eval_done, spr_valid, eval_busy, spr_count);
    end
    @(negedge clk);
    n_tests++;
    if (eval_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: done=%b want 0", eval_done);
    end
  endtask

  task automatic test_overflow();
    clear_oam();
    for (int i = 0; i < 10; i++)
      oam[i] = mk(6'(i), 8'(8'h10 + i), 10'(i * 7), 10'd50);
    spr_ready = 1'b1;
    start_line(10'd50);
    repeat (65) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({spr_valid, spr_snum, spr_index, spr_row}
          !== {1'b1, 6'(i), 6'(i), 3'd0}) begin
        n_fail++;
        $display("FAIL ovf_entry%0d: v=%b s=%0d i=%0d r=%0d", i,
                 spr_valid, spr_snum, spr_index, spr_row);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({eval_done, spr_valid, spr_count, overflow}
        !== {1'b1, 1'b0, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_done: d=%b v=%b c=%0d o=%b want 1/0/8/1",
               eval_done, spr_valid, spr_count, overflow);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({spr_count, overflow} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_hold: c=%0d o=%b want 8/1",
               spr_count, overflow);
    end
  endtask

  task automatic test_boundaries();
    logic [9:0] lines [5];
    logic [9:0] ys [5];
    logic [3:0] cnts [5];
    logic [2:0] rows [5];
    lines = '{10'd99, 10'd100, 10'd107, 10'd108, 10'd2};
    ys    = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd1020};
    cnts  = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
    rows  = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd0};
    spr_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      clear_oam();
      oam[10] = mk(6'd3, 8'd4, 10'd5, ys[t]);
      valid_cnt = 0;
      start_line(lines[t]);
      repeat (65) @(negedge clk);
      n_tests++;
      if (spr_count !== cnts[t]) begin
        n_fail++;
        $display("FAIL bnd_cnt line %0d: got %0d want %0d",
                 lines[t], spr_count, cnts[t]);
      end
      n_tests++;
      if (cnts[t] != 0) begin
        if ({spr_valid, spr_snum, spr_row}
            !== {1'b1, 6'd10, rows[t]}) begin
          n_fail++;
          $display("FAIL bnd_row line %0d: v=%b s=%0d r=%0d want r=%0d",
                   lines[t], spr_valid, spr_snum, spr_row, rows[t]);
        end
      end else if ({eval_done, spr_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL bnd_empty line %0d: done=%b v=%b want 1/0",
                 lines[t], eval_done, spr_valid);
      end
      wait_idle();
      if (cnts[t] == 0) begin
        n_tests++;
        if (valid_cnt !== 0) begin
          n_fail++;
          $display("FAIL bnd_novalid line %0d: got %0d want 0",
                   lines[t], valid_cnt);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] q_snum [$];
    logic [2:0] q_row [$];
    logic       p_v;
    logic       p_r;
    logic [5:0] p_s;
    logic [9:0] p_x;
    logic [2:0] p_row;
    logic       rdy;
    int         bad;
    int         j;
    clear_oam();
    oam[3]  = mk(6'd1, 8'hA1, 10'd11, 10'd200);
    oam[17] = mk(6'd2, 8'hA2, 10'd22, 10'd195);
    oam[40] = mk(6'd3, 8'hA3, 10'd33, 10'd193);
    spr_ready = 1'b0;
    start_line(10'd200);
    repeat (65) @(negedge clk);
    bad = 0;
    p_v = 1'b0;
    p_r = 1'b0;
    p_s = '0;
    p_x = '0;
    p_row = '0;
    j = 0;
    while (q_snum.size() < 3 && j < 60) begin
      if (p_v && !p_r && spr_valid
          && {spr_snum, spr_x, spr_row} != {p_s, p_x, p_row})
        bad++;
      rdy = (j < 5) ? 1'b0 : 1'((j % 2) == 1);
      spr_ready = rdy;
      if (spr_valid && rdy) begin
        q_snum.push_back(spr_snum);
        q_row.push_back(spr_row);
      end
      p_v = spr_valid;
      p_r = rdy;
      p_s = spr_snum;
      p_x = spr_x;
      p_row = spr_row;
      @(negedge clk);
      j++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d changes while stalled, want 0", bad);
    end
    n_tests++;
    if (q_snum.size() !== 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d entries want 3", q_snum.size());
    end else if ({q_snum[0], q_snum[1], q_snum[2],
                  q_row[0], q_row[1], q_row[2]}
                 !== {6'd3, 6'd17, 6'd40, 3'd0, 3'd5, 3'd7}) begin
      n_fail++;
      $display("FAIL bp_order: s=%0d,%0d,%0d r=%0d,%0d,%0d want 3,17,40 0,5,7",
               q_snum[0], q_snum[1], q_snum[2],
               q_row[0], q_row[1], q_row[2]);
    end
    n_tests++;
    if ({eval_done, spr_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_done: done=%b v=%b want 1/0",
               eval_done, spr_valid);
    end
    spr_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_restart();
    clear_oam();
    oam[7]  = mk(6'd7, 8'd7, 10'd7, 10'd10);
    oam[20] = mk(6'd20, 8'd20, 10'd20, 10'd298);
    done_cnt = 0;
    spr_ready = 1'b0;
    start_line(10'd12);
    repeat (30) @(negedge clk);
    n_tests++;
    if (oam_rd_addr !== 6'd30) begin
      n_fail++;
      $display("FAIL rs_addr30: got %0d want 30", oam_rd_addr);
    end
    start_line(10'd300);
    n_tests++;
    if (oam_rd_addr !== 6'd0 || oam_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_scan_restart: addr=%0d en=%b want 0/1",
               oam_rd_addr, oam_rd_en);
    end
    repeat (65) @(negedge clk);
    n_tests++;
    if ({spr_valid, spr_snum, spr_row, spr_count}
        !== {1'b1, 6'd20, 3'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL rs_lineB: v=%b s=%0d r=%0d c=%0d want 1/20/2/1",
               spr_valid, spr_snum, spr_row, spr_count);
    end
    repeat (3) @(negedge clk);
    start_line(10'd12);
    valid_cnt = 0;
    n_tests++;
    if ({oam_rd_addr, oam_rd_en, spr_valid, spr_count}
        !== {6'd0, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rs_out_restart: a=%0d en=%b v=%b c=%0d",
               oam_rd_addr, oam_rd_en, spr_valid, spr_count);
    end
    spr_ready = 1'b1;
    repeat (65) @(negedge clk);
    n_tests++;
    if ({spr_valid, spr_snum, spr_row, spr_count}
        !== {1'b1, 6'd7, 3'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL rs_lineC: v=%b s=%0d r=%0d c=%0d want 1/7/2/1",
               spr_valid, spr_snum, spr_row, spr_count);
    end
    wait_idle();
    n_tests++;
    if (done_cnt !== 1 || valid_cnt !== 1) begin
      n_fail++;
      $display("FAIL rs_final: done=%0d valid=%0d want 1/1",
               done_cnt, valid_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_overflow();
    test_boundaries();
    test_backpressure();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
